// File: rtl/msg_to_pkt_queue_pkg.sv
// Shared constants, FSM encoding and flit helpers for the message-to-packet queue.
package msg_to_pkt_queue_pkg;

    localparam int FLIT_WIDTH        = 32;
    localparam int BUS_DATA_WIDTH    = 32;
    localparam int BUS_ADDRESS_WIDTH = 24;
    localparam int BUS_SEL_WIDTH     = 4;
    localparam int MAX_PACKET_LENGHT = 5;
    localparam int QUEUE_DEPTH       = 4;
    localparam int N_BITS_POINTER    = 2;
    localparam int DATA_FLITS        = MAX_PACKET_LENGHT - 1;
    localparam int CNT_W             = 3;
    localparam int STATS_W           = 16;

    localparam int HEAD_COUNT_MSB = 31;
    localparam int HEAD_COUNT_LSB = 24;
    localparam int HEAD_ADDR_MSB  = 23;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_OVF  = 2'd2
    } asm_state_t;

    function automatic logic [FLIT_WIDTH-1:0] mask_lanes(
        input logic [BUS_DATA_WIDTH-1:0] data,
        input logic [BUS_SEL_WIDTH-1:0]  sel
    );
        logic [FLIT_WIDTH-1:0] r;
        r = '0;
        for (int b = 0; b < BUS_SEL_WIDTH; b++)
            r[b*8 +: 8] = sel[b] ? data[b*8 +: 8] : 8'h00;
        return r;
    endfunction

    function automatic logic [FLIT_WIDTH-1:0] head_flit(
        input cnt_t                         cnt,
        input logic [BUS_ADDRESS_WIDTH-1:0] addr
    );
        logic [FLIT_WIDTH-1:0] h;
        h = '0;
        h[HEAD_COUNT_MSB:HEAD_COUNT_LSB] = 8'(cnt);
        h[HEAD_ADDR_MSB:0]               = addr;
        return h;
    endfunction

    // Head flit plus data flits 1..cnt.
    function automatic logic [MAX_PACKET_LENGHT-1:0] flit_mask(input cnt_t cnt);
        logic [MAX_PACKET_LENGHT-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_PACKET_LENGHT; i++)
            m[i] = (i <= int'(cnt));
        return m;
    endfunction

endpackage

// File: rtl/msg_to_pkt_queue_if.sv
// Chunk-in / packet-out bus of the message-to-packet queue.
interface msg_to_pkt_queue_if;
    import msg_to_pkt_queue_pkg::*;

    logic                                    write_i;
    logic                                    first_i;
    logic                                    last_i;
    logic                                    abort_i;
    logic [BUS_ADDRESS_WIDTH-1:0]            address_i;
    logic [BUS_DATA_WIDTH-1:0]               data_i;
    logic [BUS_SEL_WIDTH-1:0]                sel_i;
    logic                                    ready_o;
    logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] out_link_o;
    logic [MAX_PACKET_LENGHT-1:0]            out_sel_o;
    logic                                    r_msg_to_pkt_o;
    logic                                    g_msg_to_pkt_i;
    logic [STATS_W-1:0]                      msg_count_o;
    logic [STATS_W-1:0]                      drop_count_o;

    modport master (
        output write_i, first_i, last_i, abort_i, address_i, data_i, sel_i, g_msg_to_pkt_i,
        input  ready_o, out_link_o, out_sel_o, r_msg_to_pkt_o, msg_count_o, drop_count_o
    );

    modport slave (
        input  write_i, first_i, last_i, abort_i, address_i, data_i, sel_i, g_msg_to_pkt_i,
        output ready_o, out_link_o, out_sel_o, r_msg_to_pkt_o, msg_count_o, drop_count_o
    );
endinterface

// File: rtl/msg_to_pkt_queue_assembler.sv
// Message assembler: tracks the chunk position inside the slot being filled and
// decides per accepted chunk whether to write a flit, commit or drop.
module msg_to_pkt_queue_assembler
    import msg_to_pkt_queue_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         accept,
    input  logic                         first,
    input  logic                         last,
    input  logic                         abort,
    input  logic [BUS_ADDRESS_WIDTH-1:0] address,
    output logic                         chunk_we,
    output cnt_t                         chunk_idx,
    output logic                         commit,
    output cnt_t                         commit_cnt,
    output logic [BUS_ADDRESS_WIDTH-1:0] commit_addr,
    output logic                         drop
);

    asm_state_t                   state;
    cnt_t                         count;
    logic [BUS_ADDRESS_WIDTH-1:0] addr_q;
    logic                         take;
    logic                         restart;
    logic                         full_msg;

    assign take     = accept && !abort;
    assign restart  = take && first && (state != ST_OVF);
    assign full_msg = (count == cnt_t'(DATA_FLITS));

    always_comb begin
        chunk_we    = 1'b0;
        chunk_idx   = cnt_t'(1);
        commit      = 1'b0;
        commit_cnt  = count;
        commit_addr = addr_q;
        drop        = 1'b0;
        if (restart) begin
            chunk_we    = 1'b1;
            commit      = last;
            commit_cnt  = cnt_t'(1);
            commit_addr = address;
        end else if (take && state == ST_FILL) begin
            if (full_msg) begin
                drop = last;
            end else begin
                chunk_we   = 1'b1;
                chunk_idx  = count + cnt_t'(1);
                commit     = last;
                commit_cnt = count + cnt_t'(1);
            end
        end else if (take && state == ST_OVF) begin
            drop = last;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            count <= '0;
        end else if (abort) begin
            state <= ST_IDLE;
        end else if (restart) begin
            count <= cnt_t'(1);
            state <= last ? ST_IDLE : ST_FILL;
        end else if (take) begin
            case (state)
                ST_FILL: begin
                    if (full_msg) begin
                        state <= last ? ST_IDLE : ST_OVF;
                    end else begin
                        count <= count + cnt_t'(1);
                        state <= last ? ST_IDLE : ST_FILL;
                    end
                end
                ST_OVF:  if (last) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (restart)
            addr_q <= address;
    end

endmodule

// File: rtl/msg_to_pkt_queue.sv
// Circular packet-slot queue of the MESSAGE2PACKET stage. Optional statistics
// counters are built when MSG2PKT_STATS_EN is defined.
module msg_to_pkt_queue
    import msg_to_pkt_queue_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    msg_to_pkt_queue_if.slave  bus
);

    logic [FLIT_WIDTH-1:0]        flit_mem [QUEUE_DEPTH][MAX_PACKET_LENGHT];
    logic [MAX_PACKET_LENGHT-1:0] sel_mem  [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0]       valid;
    logic [N_BITS_POINTER-1:0]    head;
    logic [N_BITS_POINTER-1:0]    tail;

    logic                         accept;
    logic                         take;
    logic                         chunk_we;
    cnt_t                         chunk_idx;
    logic                         commit;
    cnt_t                         commit_cnt;
    logic [BUS_ADDRESS_WIDTH-1:0] commit_addr;
    logic                         drop;

    assign bus.ready_o        = !valid[tail];
    assign accept             = bus.write_i && bus.ready_o;
    assign take               = bus.g_msg_to_pkt_i && valid[head];
    assign bus.r_msg_to_pkt_o = valid[head];
    assign bus.out_sel_o      = valid[head] ? sel_mem[head] : '0;

    for (genvar k = 0; k < MAX_PACKET_LENGHT; k++) begin : g_link
        assign bus.out_link_o[k*FLIT_WIDTH +: FLIT_WIDTH] = flit_mem[head][k];
    end

    msg_to_pkt_queue_assembler u_asm (
        .clk         (clk),
        .rst         (rst),
        .accept      (accept),
        .first       (bus.first_i),
        .last        (bus.last_i),
        .abort       (bus.abort_i),
        .address     (bus.address_i),
        .chunk_we    (chunk_we),
        .chunk_idx   (chunk_idx),
        .commit      (commit),
        .commit_cnt  (commit_cnt),
        .commit_addr (commit_addr),
        .drop        (drop)
    );

    // Slot payload carries no reset; the valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (chunk_we)
            flit_mem[tail][chunk_idx] <= mask_lanes(bus.data_i, bus.sel_i);
        if (commit) begin
            flit_mem[tail][0] <= head_flit(commit_cnt, commit_addr);
            sel_mem[tail]     <= flit_mask(commit_cnt);
        end
    end

    // Commit and grant hit different slots: commit needs the tail slot free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            if (commit) begin
                valid[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            if (take) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
        end
    end

`ifdef MSG2PKT_STATS_EN
    logic [STATS_W-1:0] msg_cnt;
    logic [STATS_W-1:0] drop_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msg_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (commit && msg_cnt != '1)
                msg_cnt <= msg_cnt + 1'b1;
            if (drop && drop_cnt != '1)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign bus.msg_count_o  = msg_cnt;
    assign bus.drop_count_o = drop_cnt;
`else
    logic stats_unused;
    assign stats_unused     = drop;
    assign bus.msg_count_o  = '0;
    assign bus.drop_count_o = '0;
`endif

endmodule

// File: tb/tb_msg_to_pkt_queue.sv
// Directed bench for msg_to_pkt_queue; counter expectations follow MSG2PKT_STATS_EN.
module tb_msg_to_pkt_queue;
    import msg_to_pkt_queue_pkg::*;

`ifdef MSG2PKT_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    msg_to_pkt_queue_if bus ();

    msg_to_pkt_queue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] flit(input int k);
        return bus.out_link_o[k*FLIT_WIDTH +: FLIT_WIDTH];
    endfunction

    task automatic cyc(input logic w, input logic f, input logic l, input logic ab,
                       input logic [23:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic g);
        bus.write_i = w;  bus.first_i = f;  bus.last_i = l;  bus.abort_i = ab;
        bus.address_i = a; bus.data_i = d; bus.sel_i = s; bus.g_msg_to_pkt_i = g;
        @(posedge clk);
        #1;
        bus.write_i = 1'b0; bus.first_i = 1'b0; bus.last_i = 1'b0; bus.abort_i = 1'b0;
        bus.g_msg_to_pkt_i = 1'b0;
    endtask

    task automatic chunk(input logic f, input logic l, input logic [23:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        cyc(1'b1, f, l, 1'b0, a, d, s, 1'b0);
    endtask

    task automatic grant();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.write_i = 1'b0; bus.first_i = 1'b0; bus.last_i = 1'b0; bus.abort_i = 1'b0;
        bus.address_i = '0; bus.data_i = '0; bus.sel_i = '0; bus.g_msg_to_pkt_i = 1'b0;

        // Reset values while rst is held low
        #12;
        check("rst_ready", bus.ready_o, 1);
        check("rst_req", bus.r_msg_to_pkt_o, 0);
        check("rst_sel", bus.out_sel_o, 0);
        check("rst_msgcnt", bus.msg_count_o, 0);
        check("rst_dropcnt", bus.drop_count_o, 0);
        @(negedge clk);
        rst = 1'b1;

        // Single-chunk message
        chunk(1, 1, 24'h001234, 32'hDEADBEEF, 4'hF);
        check("single_req", bus.r_msg_to_pkt_o, 1);
        check("single_sel", bus.out_sel_o, 5'b00011);
        check("single_f0", flit(0), 32'h01001234);
        check("single_f1", flit(1), 32'hDEADBEEF);
        check("single_msgcnt", bus.msg_count_o, STATS ? 1 : 0);
        grant();
        check("single_gnt_req", bus.r_msg_to_pkt_o, 0);

        // Chunk without first in IDLE is ignored
        chunk(0, 1, 24'h000BAD, 32'h0BAD0BAD, 4'hF);
        check("nofirst_req", bus.r_msg_to_pkt_o, 0);

        // 4-chunk burst, chunk 3 with only the low two lanes enabled
        chunk(1, 0, 24'hABCDEF, 32'h11111111, 4'hF);
        chunk(0, 0, 24'h0,      32'h22222222, 4'hF);
        chunk(0, 0, 24'h0,      32'h33333333, 4'b0011);
        check("burst_midreq", bus.r_msg_to_pkt_o, 0);
        chunk(0, 1, 24'h0,      32'h44444444, 4'hF);
        check("burst_req", bus.r_msg_to_pkt_o, 1);
        check("burst_sel", bus.out_sel_o, 5'b11111);
        check("burst_f0cnt", flit(0) >> 24, 4);
        check("burst_f0", flit(0), 32'h04ABCDEF);
        check("burst_f1", flit(1), 32'h11111111);
        check("burst_f3", flit(3), 32'h00003333);
        check("burst_f4", flit(4), 32'h44444444);
        grant();
        check("burst_gnt_req", bus.r_msg_to_pkt_o, 0);
        check("burst_gnt_sel", bus.out_sel_o, 0);

        // Fill all slots without grants
        for (int k = 1; k <= 4; k++)
            chunk(1, 1, 24'(k), 32'hA0 + 32'(k), 4'hF);
        check("full_ready", bus.ready_o, 0);
        check("full_req", bus.r_msg_to_pkt_o, 1);
        chunk(1, 0, 24'h0000EE, 32'hEEEEEEEE, 4'hF);
        chunk(0, 1, 24'h0,      32'hEEEEEEEE, 4'hF);
        check("full_ignored_ready", bus.ready_o, 0);
        check("full_head_f0", flit(0), 32'h01000001);
        grant();
        check("full_gnt_ready", bus.ready_o, 1);
        check("full_gnt_f0", flit(0), 32'h01000002);
        // Commit and grant in the same cycle, then refill to full
        cyc(1, 1, 1, 0, 24'h000005, 32'hA5, 4'hF, 1);
        check("same_cyc_ready", bus.ready_o, 1);
        check("same_cyc_f0", flit(0), 32'h01000003);
        chunk(1, 1, 24'h000006, 32'hA6, 4'hF);
        check("refull_ready", bus.ready_o, 0);
        for (int k = 3; k <= 6; k++) begin
            check("drain_req", bus.r_msg_to_pkt_o, 1);
            check("drain_f0", flit(0), 32'h01000000 | 32'(k));
            check("drain_f1", flit(1), 32'hA0 + 32'(k));
            grant();
        end
        check("drain_empty_req", bus.r_msg_to_pkt_o, 0);
        check("drain_empty_ready", bus.ready_o, 1);

        // Overflow: six chunks in one message
        chunk(1, 0, 24'h000070, 32'h70, 4'hF);
        for (int k = 2; k <= 5; k++)
            chunk(0, 0, 24'h0, 32'h70 + 32'(k), 4'hF);
        chunk(0, 1, 24'h0, 32'h76, 4'hF);
        check("ovf_req", bus.r_msg_to_pkt_o, 0);
        check("ovf_ready", bus.ready_o, 1);
        check("ovf_dropcnt", bus.drop_count_o, STATS ? 1 : 0);
        chunk(1, 1, 24'h000077, 32'h77777777, 4'hF);
        check("post_ovf_req", bus.r_msg_to_pkt_o, 1);
        check("post_ovf_f0", flit(0), 32'h01000077);
        check("post_ovf_sel", bus.out_sel_o, 5'b00011);
        grant();

        // Abort after two chunks (abort beats a simultaneous last chunk)
        chunk(1, 0, 24'h000055, 32'h55555555, 4'hF);
        chunk(0, 0, 24'h0,      32'h56565656, 4'hF);
        cyc(1, 0, 1, 1, 24'h0, 32'h57575757, 4'hF, 0);
        check("abort_req", bus.r_msg_to_pkt_o, 0);
        chunk(1, 1, 24'h000066, 32'h66666666, 4'hF);
        check("abort_new_req", bus.r_msg_to_pkt_o, 1);
        check("abort_new_f0", flit(0), 32'h01000066);
        check("abort_new_f1", flit(1), 32'h66666666);
        check("abort_new_sel", bus.out_sel_o, 5'b00011);
        check("abort_msgcnt", bus.msg_count_o, STATS ? 10 : 0);
        grant();

        // Reset in the middle of a message with two slots valid
        chunk(1, 1, 24'h000081, 32'h81, 4'hF);
        chunk(1, 1, 24'h000082, 32'h82, 4'hF);
        chunk(1, 0, 24'h000090, 32'h90, 4'hF);
        check("prerst_req", bus.r_msg_to_pkt_o, 1);
        rst = 1'b0;
        #1;
        check("midrst_req", bus.r_msg_to_pkt_o, 0);
        check("midrst_ready", bus.ready_o, 1);
        check("midrst_sel", bus.out_sel_o, 0);
        @(negedge clk);
        rst = 1'b1;
        chunk(0, 1, 24'h0, 32'h91, 4'hF);
        check("postrst_stale_req", bus.r_msg_to_pkt_o, 0);
        chunk(1, 1, 24'h000099, 32'h99999999, 4'hF);
        check("postrst_req", bus.r_msg_to_pkt_o, 1);
        check("postrst_f0", flit(0), 32'h01000099);
        check("postrst_f1", flit(1), 32'h99999999);
        check("postrst_msgcnt", bus.msg_count_o, STATS ? 1 : 0);
        check("postrst_dropcnt", bus.drop_count_o, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/msg_to_pkt_queue.md
# msg_to_pkt_queue

Queue of the MESSAGE2PACKET stage of the NIC: the return direction of the PACKET2MESSAGE path. It receives bus messages, chunk by chunk, from the WISHBONE slave interface and packs each one into a packet (head flit plus data flits) in a circular slot queue. It then offers completed packets to the output flit buffer through a request/grant handshake.

## Interface
- FLIT_WIDTH, 32, flit width; equal to BUS_DATA_WIDTH
- BUS_DATA_WIDTH, 32, bus data chunk width
- BUS_ADDRESS_WIDTH, 24, bus address width
- BUS_SEL_WIDTH, 4, byte enables per chunk
- MAX_PACKET_LENGHT, 5, flits per packet (1 head + 4 data)
- QUEUE_DEPTH, 4, packet slots (power of 2)
- N_BITS_POINTER, 2, log2(QUEUE_DEPTH)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- write_i  in  1  chunk strobe from slave interface
- first_i  in  1  chunk is first of a message
- last_i  in  1  chunk is last of a message
- abort_i  in  1  bus error/retry; discard the partial message
- address_i  in  BUS_ADDRESS_WIDTH  message address, sampled with first_i
- data_i  in  BUS_DATA_WIDTH  chunk data
- sel_i  in  BUS_SEL_WIDTH  byte enables of the chunk
- ready_o  out  1  a free slot exists; chunks are accepted
- out_link_o  out  MAX_PACKET_LENGHT*FLIT_WIDTH  head-slot packet, flit 0 in the LSBs
- out_sel_o  out  MAX_PACKET_LENGHT  valid-flit mask of the head slot
- r_msg_to_pkt_o  out  1  packet available request
- g_msg_to_pkt_i  in  1  grant; packet taken by the output buffer
- msg_count_o  out  16  committed messages (statistics)
- drop_count_o  out  16  dropped messages (statistics)

## Operation
- Storage: per slot, MAX_PACKET_LENGHT flits, a sel mask and a valid bit. Pointers are tail (slot being filled) and head (oldest complete). Both wrap QUEUE_DEPTH-1 to 0.
- ready_o = !valid[tail]. A chunk is accepted only when write_i && ready_o.
- Assembler FSM states:
  - IDLE: an accepted chunk with first_i goes to FILL, stores address_i, writes the chunk to flit 1 and sets count=1. Accepted chunks without first_i are ignored.
  - FILL: each accepted chunk goes to flit count+1 and increments count. A chunk with first_i restarts the message; the previous partial data is discarded.
  - OVF: entered when a 5th data chunk arrives. Further chunks are discarded. last_i drops the message and returns to IDLE.
- Byte lanes with sel_i low are stored as zero.
- Commit: on an accepted last_i in IDLE (with first_i) or in FILL:
  - head flit = {count zero-extended to 8 bits, address}.
  - sel mask = bit0 plus bits 1..count.
  - valid[tail] is set, tail advances, FSM returns to IDLE.
- A first_i && last_i chunk commits a 1-data-flit packet.
- abort_i has priority over write_i in any state: FSM goes to IDLE and tail does not move.
- r_msg_to_pkt_o = valid[head].
- out_sel_o = the head mask while valid[head] is set, else 0.
- A grant while the request is high clears valid[head] and advances head. A grant without a request is ignored.
- A commit and a grant in the same cycle are both performed. They touch distinct slots because a commit requires the tail slot to be free.

## Timing
- Reset: FSM IDLE; pointers, valid bits and counters 0. With valid cleared, ready_o=1, r_msg_to_pkt_o=0 and out_sel_o=0 during reset. Slot data is not reset.
- Reset mid-message: the partial message is lost; no commit occurs.
- Commit latency: r_msg_to_pkt_o rises the cycle after the edge that accepts last_i.
- A grant is observed at the clock edge. The next request/out_link_o values appear in the same cycle after that edge, so back-to-back grants drain one packet per cycle.
- Full: after QUEUE_DEPTH commits with no grants, ready_o=0 in the cycle after the last commit. ready_o returns to 1 one cycle after a grant frees the tail slot.

## Configuration
- MSG2PKT_STATS_EN defined:
  - msg_count_o increments on each commit.
  - drop_count_o increments on each overflow drop.
  - Both saturate at 16'hFFFF.
- Undefined: both ports are tied to 0 and the counter logic is absent.

## Structure
- NIC-defines.v holds the shared constants:
  - FLIT_WIDTH, BUS_* widths, MAX_PACKET_LENGHT, QUEUE_DEPTH
  - FSM state encodings
  - head-flit field ranges (count [31:24], address [23:0])
- Sub-module msg2pkt_assembler contains the FSM, count and partial-slot write enables. The top level holds the slot array, pointers, valid bits and statistics.

## Test plan
- Single chunk: first_i=last_i=1, address 24'h00_1234, data 32'hDEADBEEF. Next cycle: r_msg_to_pkt_o=1, out_sel_o=5'b00011, flit0=32'h01001234, flit1=32'hDEADBEEF.
- 4-chunk burst with sel_i=4'b0011 on chunk 3: out_sel_o=5'b11111, flit0[31:24]=4, flit3 upper bytes=0. A grant clears the request next cycle.
- Fill 4 slots with no grant: ready_o=0 and a 5th burst is ignored. One grant makes ready_o=1 next cycle; commit and grant in the same cycle leave exactly 4 valid slots.
- Overflow with 6 chunks: no commit, tail unchanged, drop_count_o=1 (STATS_EN). Then a 1-chunk message commits normally.
- abort_i after 2 chunks, then a new 1-chunk message: only the new packet appears, with count 1.
- rst asserted mid-FILL with 2 slots valid: r_msg_to_pkt_o=0 and ready_o=1 immediately; after release, a new message commits into slot 0.
